// File: rtl/sawtooth_pkg.sv
// rtl/sawtooth_pkg.sv - shared FSM state encoding, guard constant and guard predicate
package sawtooth_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    FINISH  = 3'd4
  } state_e;

  localparam logic [31:0] GUARD_X = 32'h3F000000;

  // Results that would freeze the map: Inf/NaN exponent or a signed zero.
  function automatic logic guard_hit(input logic [31:0] v);
    return (v[30:23] == 8'hFF) || (v[30:0] == 31'd0);
  endfunction

endpackage

// File: rtl/sawtooth_keystream_if.sv
// rtl/sawtooth_keystream_if.sv - control, sawtooth-pipeline and keystream signals of the block
interface sawtooth_keystream_if #(
  parameter int PRECISION = 32
);
  logic                 start;
  logic [PRECISION-1:0] seed_x;
  logic [PRECISION-1:0] epsilon;
  logic [15:0]          n_iter;
  logic [PRECISION-1:0] saw_x;
  logic [PRECISION-1:0] saw_eps;
  logic                 saw_valid;
  logic [PRECISION-1:0] saw_result;
  logic [7:0]           ks_data;
  logic                 ks_valid;
  logic                 ks_ready;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    input  start, seed_x, epsilon, n_iter, saw_result, ks_ready,
    output saw_x, saw_eps, saw_valid, ks_data, ks_valid, busy, done, err
  );

  modport slave (
    output start, seed_x, epsilon, n_iter, saw_result, ks_ready,
    input  saw_x, saw_eps, saw_valid, ks_data, ks_valid, busy, done, err
  );
endinterface

// File: rtl/sawtooth_keystream_fifo.sv
// rtl/sawtooth_keystream_fifo.sv - keystream byte buffer; a full buffer accepts a push when popped in the same cycle
module ks_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/sawtooth_keystream.sv
// rtl/sawtooth_keystream.sv - iterates an external sawtooth pipeline and emits keystream bytes
// Optional result guard: define SAWTOOTH_KS_GUARD_EN.
module sawtooth_keystream
  import sawtooth_pkg::*;
#(
  parameter int PRECISION   = 32,
  parameter int SAW_LATENCY = 12,
  parameter int WARMUP      = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  sawtooth_keystream_if.master bus
);
  localparam logic [2:0]  S_IDLE    = IDLE;
  localparam logic [2:0]  S_ISSUE   = ISSUE;
  localparam logic [2:0]  S_WAIT    = WAIT;
  localparam logic [2:0]  S_CAPTURE = CAPTURE;
  localparam logic [2:0]  S_FINISH  = FINISH;
  localparam int          WCW         = (SAW_LATENCY > 1) ? $clog2(SAW_LATENCY) : 1;
  localparam logic [15:0] WARMUP_INIT = 16'(WARMUP);

  logic [2:0]           state_q, state_d;
  logic [PRECISION-1:0] x_q, x_d, eps_q, eps_d;
  logic [15:0]          bytes_q, bytes_d, warm_q, warm_d;
  logic [WCW-1:0]       wait_q, wait_d;
  logic                 err_q, err_d, done_q, done_d;
  logic [PRECISION-1:0] res_fix;
  logic                 res_bad, push, fifo_full, fifo_empty, fifo_ready;
  logic [7:0]           push_data, pop_data;

`ifdef SAWTOOTH_KS_GUARD_EN
  assign res_bad = guard_hit(32'(bus.saw_result));
  assign res_fix = res_bad ? PRECISION'(GUARD_X) : bus.saw_result;
`else
  assign res_bad = 1'b0;
  assign res_fix = bus.saw_result;
`endif

  assign push_data  = res_fix[7:0] ^ res_fix[15:8];
  assign fifo_ready = !fifo_full || bus.ks_ready;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    eps_d   = eps_q;
    bytes_d = bytes_q;
    warm_d  = warm_q;
    wait_d  = wait_q;
    err_d   = err_q;
    done_d  = 1'b0;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          x_d     = bus.seed_x;
          eps_d   = bus.epsilon;
          bytes_d = bus.n_iter;
          warm_d  = WARMUP_INIT;
          state_d = (bus.n_iter == 16'd0) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_d  = WCW'(SAW_LATENCY - 2);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == '0) state_d = S_CAPTURE;
        else              wait_d  = wait_q - 1'b1;
      end
      S_CAPTURE: begin
        if (warm_q != 16'd0) begin
          x_d     = res_fix;
          err_d   = err_q | res_bad;
          warm_d  = warm_q - 16'd1;
          state_d = S_ISSUE;
        end else if (fifo_ready) begin
          // Without buffer room the result is left on saw_result and retried.
          x_d     = res_fix;
          err_d   = err_q | res_bad;
          push    = 1'b1;
          bytes_d = bytes_q - 16'd1;
          state_d = (bytes_q == 16'd1) ? S_FINISH : S_ISSUE;
        end
      end
      S_FINISH: begin
        if (fifo_empty) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      eps_q   <= '0;
      bytes_q <= '0;
      warm_q  <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      eps_q   <= eps_d;
      bytes_q <= bytes_d;
      warm_q  <= warm_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  ks_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .full      (fifo_full),
    .pop       (bus.ks_ready),
    .pop_data  (pop_data),
    .empty     (fifo_empty)
  );

  assign bus.saw_valid = (state_q == S_ISSUE);
  assign bus.saw_x     = bus.saw_valid ? x_q : '0;
  assign bus.saw_eps   = bus.saw_valid ? eps_q : '0;
  assign bus.ks_valid  = !fifo_empty;
  assign bus.ks_data   = pop_data;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: doc/sawtooth_keystream.md
SAWTOOTH_KEYSTREAM -- requirements
Module: sawtooth_keystream

Interface
REQ-001 SHALL have parameter PRECISION, default 32, float word width (IEEE-754 single).
REQ-002 SHALL have parameter SAW_LATENCY, default 12, fixed cycles from saw_valid to the matching saw_result.
REQ-003 SHALL have parameter WARMUP, default 16, initial iterations discarded.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of 2).
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a run.
REQ-008 SHALL have port seed_x  input  PRECISION  initial x, sampled on accepted start.
REQ-009 SHALL have port epsilon  input  PRECISION  map parameter, sampled on accepted start.
REQ-010 SHALL have port n_iter  input  16  keystream bytes to emit, sampled on accepted start.
REQ-011 SHALL have port saw_x  output  PRECISION  x operand to the sawtooth pipeline.
REQ-012 SHALL have port saw_eps  output  PRECISION  epsilon operand to the sawtooth pipeline.
REQ-013 SHALL have port saw_valid  output  1  operands valid this cycle.
REQ-014 SHALL have port saw_result  input  PRECISION  sawtooth pipeline output.
REQ-015 SHALL have port ks_data  output  8  keystream byte.
REQ-016 SHALL have port ks_valid  output  1  ks_data valid.
REQ-017 SHALL have port ks_ready  input  1  consumer accepts; transfer when ks_valid and ks_ready are both high.
REQ-018 SHALL have port busy  output  1  run in progress.
REQ-019 SHALL have port done  output  1  one-cycle pulse at end of run.
REQ-020 SHALL have port err  output  1  sticky guard-hit flag.

Function
REQ-021 SHALL implement FSM states IDLE, ISSUE, WAIT, CAPTURE, FINISH.
REQ-022 SHALL, in IDLE on start, latch seed_x, epsilon, n_iter and WARMUP; go to ISSUE, or to FINISH if n_iter==0.
REQ-023 SHALL, in ISSUE, drive saw_x=x_reg, saw_eps=eps_reg, saw_valid=1 for exactly one cycle, then go to WAIT.
REQ-024 SHALL, in WAIT, count SAW_LATENCY-1 cycles, then go to CAPTURE so that saw_result is sampled exactly SAW_LATENCY cycles after saw_valid.
REQ-025 SHALL, in CAPTURE, load x_reg<=saw_result.
REQ-026 SHALL, in CAPTURE with warm-up count nonzero, decrement it without pushing a byte.
REQ-027 SHALL, in CAPTURE with warm-up done, push saw_result[7:0]^saw_result[15:8] and decrement the byte count.
REQ-028 SHALL stall in CAPTURE, without loading x_reg or pushing, while the FIFO is full and a push is required.
REQ-029 SHALL, after CAPTURE, go to FINISH when the byte count reaches 0, else to ISSUE; one iteration takes SAW_LATENCY+1 cycles when unstalled.
REQ-030 SHALL, in FINISH, wait until the FIFO is empty, pulse done for one cycle, then return to IDLE.
REQ-031 SHALL drive busy high in every state except IDLE.
REQ-032 SHALL ignore start when not in IDLE.
REQ-033 SHALL support FIFO push and pop in the same cycle when full; ks_valid=!empty; byte order preserved.
REQ-034 SHALL drive saw_x/saw_eps to 0 when saw_valid is low.

Reset
REQ-035 SHALL, on reset, enter IDLE; clear busy, done, ks_valid, saw_valid, saw_x, saw_eps, ks_data, err, counters and FIFO pointers.
REQ-036 SHALL abort a run on reset in any state, emitting no further bytes and no done pulse.

Configuration
REQ-037 SHALL, with SAWTOOTH_KS_GUARD_EN defined, replace a captured result with exponent 8'hFF or value +/-0 by 32'h3F000000 before feedback and byte extraction, and set err.
REQ-038 SHALL, without SAWTOOTH_KS_GUARD_EN, feed the result back unchanged and tie err to 0.

Structure
REQ-039 SHALL place the FSM state enum and the constant GUARD_X=32'h3F000000 in the shared package sawtooth_pkg.
REQ-040 SHALL implement the output buffer as sub-module ks_fifo, parameterised by FIFO_DEPTH; the sawtooth pipeline itself stays outside this block.

Verification
REQ-041 SHALL check reset: all outputs 0 after reset; after a reset asserted during WAIT, busy=0 next cycle and no done pulse.
REQ-042 SHALL check basic run: WARMUP=0, seed 32'h3FE00000, eps 32'h3D4CCCCD, n_iter=3, ks_ready=1, bench model of SAW_LATENCY=12 -> saw_valid every 13 cycles; 3 bytes match the model XOR; done once.
REQ-043 SHALL check backpressure: n_iter=6, ks_ready=0 -> 4 bytes buffered, no 5th push; ks_ready=1 -> all 6 bytes delivered in order, then done.
REQ-044 SHALL check n_iter=0: start -> no saw_valid; done pulses 2 cycles after start.
REQ-045 SHALL check start while busy: no effect on the run or latched operands.
REQ-046 SHALL check the guard: model returns 32'h7FC00000 -> with the macro, next saw_x=32'h3F000000 and err=1; without it, next saw_x=32'h7FC00000 and err=0.
